// File: rtl/bk_addsub_pipe.sv
// bk_addsub_pipe: pipelined Brent-Kung add/sub with C/V/Z/N flags; define BK_MID_PIPE_EN for a 3-stage build
module bk_addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);
  localparam int LG = $clog2(WIDTH);
  logic s1_v, s1_cin, c0, s2_en, mid_en, mid_v, m_c0, m_a, unused_q;
  logic [1:0] s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, b_eff, pg, gg, m_g, m_q, m_p, cg, sum;
  assign s2_en = !out_valid || out_ready;
  assign in_ready = !rst_n || !s1_v || mid_en;
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_cin <= 1'b0;
      s1_op <= 2'b00;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_cin <= in_cin;
        s1_op <= in_op;
      end
    end
  assign b_eff = s1_op[0] ? ~s1_b : s1_b;
  assign c0 = s1_op[1] ? s1_cin : s1_op[0];
  assign pg = s1_a ^ b_eff;
  assign gg = s1_a & b_eff;
  genvar l, i;
  generate
    for (l = 0; l <= LG; l++) begin : u
      logic [WIDTH-1:0] g, p;
      if (l == 0) begin : z
        assign g = {gg[WIDTH-1:1], gg[0] | (pg[0] & c0)};
        assign p = pg;
      end else begin : s
        for (i = 0; i < WIDTH; i++) begin : b
          if ((i + 1) % (2 ** l) == 0) begin : k
            assign g[i] = u[l-1].g[i] | (u[l-1].p[i] & u[l-1].g[i-2**(l-1)]);
            assign p[i] = u[l-1].p[i] & u[l-1].p[i-2**(l-1)];
          end else begin : t
            assign g[i] = u[l-1].g[i];
            assign p[i] = u[l-1].p[i];
          end
        end
      end
    end
  endgenerate
`ifdef BK_MID_PIPE_EN
  assign mid_en = !mid_v || s2_en;
  always_ff @(posedge clk)
    if (!rst_n) begin
      mid_v <= 1'b0;
      m_g <= '0;
      m_q <= '0;
      m_p <= '0;
      m_c0 <= 1'b0;
      m_a <= 1'b0;
    end else begin
      if (mid_en) mid_v <= s1_v;
      if (s1_v && mid_en) begin
        m_g <= u[LG].g;
        m_q <= u[LG].p;
        m_p <= pg;
        m_c0 <= c0;
        m_a <= s1_a[WIDTH-1];
      end
    end
`else
  assign mid_en = s2_en;
  assign mid_v = s1_v;
  assign m_g = u[LG].g;
  assign m_q = u[LG].p;
  assign m_p = pg;
  assign m_c0 = c0;
  assign m_a = s1_a[WIDTH-1];
`endif
  generate
    for (l = 0; l < LG; l++) begin : d
      logic [WIDTH-1:0] g;
      if (l == 0) begin : z
        assign g = m_g;
      end else begin : s
        for (i = 0; i < WIDTH; i++) begin : b
          if ((i + 1) % (2 ** (LG - l)) == 2 ** (LG - 1 - l) && i >= 2 ** (LG - l)) begin : k
            assign g[i] = d[l-1].g[i] | (m_q[i] & d[l-1].g[i-2**(LG-1-l)]);
          end else begin : t
            assign g[i] = d[l-1].g[i];
          end
        end
      end
    end
  endgenerate
  assign cg = d[LG-1].g;
  assign sum = m_p ^ {cg[WIDTH-2:0], m_c0};
  assign unused_q = &{1'b0, m_q};
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      out_c <= 1'b0;
      out_v <= 1'b0;
      out_z <= 1'b0;
      out_n <= 1'b0;
    end else begin
      if (s2_en) out_valid <= mid_v;
      if (mid_v && s2_en) begin
        out_sum <= sum;
        out_c <= cg[WIDTH-1];
        out_v <= !m_p[WIDTH-1] && (sum[WIDTH-1] != m_a);
        out_z <= sum == '0;
        out_n <= sum[WIDTH-1];
      end
    end
endmodule

// File: tb/tb_bk_addsub_pipe.sv
// tb_bk_addsub_pipe: scoreboard bench with directed hand-computed vectors
module tb_bk_addsub_pipe;
  localparam int W = 8;
`ifdef BK_MID_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_cin, out_valid, out_ready, out_c, out_v, out_z, out_n;
  logic [1:0] in_op;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [11:0] cur_exp, got, held, want;
  logic [11:0] q[$];
  logic [30:0] vec [18];
  logic hold = 1'b0;
  int tests = 0, fails = 0, acc = 0, rdy_mode = 1;
  int lat, a0, stale, gap;
  always #5 clk = ~clk;
  bk_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );
  initial forever begin
    @(posedge clk);
    if (!rst_n) q.delete();
    else if (in_valid && in_ready) begin
      q.push_back(cur_exp);
      acc++;
    end
  end
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : rdy_mode[0];
    end
  end
  initial forever begin
    @(negedge clk);
    got = {out_sum, out_c, out_v, out_z, out_n};
    if (rst_n && hold) begin
      tests++;
      if (!out_valid || got !== held) begin
        fails++;
        $display("FAIL hold_stable got=%h valid=%b want=%h", got, out_valid, held);
      end
    end
    hold = rst_n && out_valid && !out_ready;
    held = got;
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result got=%h want=none", got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL result got=%h want=%h", got, want);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, g, e);
    end
  endtask
  task automatic send(input logic [30:0] v);
    int k = 0;
    logic r;
    {in_op, in_a, in_b, in_cin, cur_exp} = v;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      k++;
    end while (!r && k < 50);
    #1 in_valid = 1'b0;
    if (!r) check("send_timeout", 0, 1);
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1 check("drain_empty", q.size(), 0);
  endtask
  initial begin
    #200000 $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec = '{
      {2'b00, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1010},
      {2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1100},
      {2'b01, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0001},
      {2'b10, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0101},
      {2'b11, 8'h05, 8'h03, 1'b0, 8'h01, 4'b1000},
      {2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101},
      {2'b00, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1110},
      {2'b01, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010},
      {2'b10, 8'hFF, 8'hFF, 1'b1, 8'hFF, 4'b1001},
      {2'b11, 8'h05, 8'h03, 1'b1, 8'h02, 4'b1000},
      {2'b11, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0001},
      {2'b01, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b0101},
      {2'b00, 8'h55, 8'hAA, 1'b0, 8'hFF, 4'b0001},
      {2'b10, 8'h0F, 8'hF0, 1'b1, 8'h00, 4'b1010},
      {2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000},
      {2'b00, 8'h02, 8'h02, 1'b0, 8'h04, 4'b0000},
      {2'b00, 8'h03, 8'h03, 1'b0, 8'h06, 4'b0000},
      {2'b00, 8'h04, 8'h04, 1'b0, 8'h08, 4'b0000}
    };
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_op = 2'b00;
    cur_exp = '0;
    repeat (3) @(posedge clk);
    #1 check("ready_in_reset", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {out_sum, out_c, out_v, out_z, out_n}, 0);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1 send(vec[0]);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, L);
    for (int j = 1; j < 14; j++) send(vec[j]);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #3 a0 = acc;
    fork
      for (int j = 14; j < 18; j++) send(vec[j]);
    join_none
    repeat (6) @(posedge clk);
    #1 check("bp_accepted", acc - a0, L);
    check("bp_in_ready_low", in_ready, 0);
    rdy_mode = 1;
    wait fork;
    drain();
    send(vec[5]);
    send(vec[6]);
    rst_n = 1'b0;
    #1 check("ready_during_reset", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_outputs", {out_sum, out_c, out_v, out_z, out_n}, 0);
    check("flush_ready", in_ready, 1);
    check("flush_queue", q.size(), 0);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);
    rdy_mode = 2;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 18; j++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        send(vec[j]);
      end
    rdy_mode = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
